// File: rtl/spectro_pkg.sv
// Shared types and constants for the spectrogram output path.
package spectro_pkg;

  localparam int unsigned WORD_W   = 12;
  localparam int unsigned SLOT_LEN = 12;
  localparam int unsigned CNT_W    = $clog2(SLOT_LEN);
  localparam int unsigned ENTRY_W  = WORD_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  typedef struct packed {
    logic              last;
    logic [WORD_W-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/word_fifo.sv
// Synchronous FIFO with occupancy count; head is visible on rdata without a pop.
module word_fifo #(
  parameter int unsigned WIDTH = 13,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LVL_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/piso_word_scheduler.sv
// Feeds a 12-bit PISO: one load pulse per 12-cycle slot, back-to-back words,
// and qualifiers aligned with the PISO serial output.
module piso_word_scheduler
  import spectro_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WORD_W-1:0]         in_data,
  input  logic                      in_last,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      sl,
  output logic [WORD_W-1:0]         parallel_out,
  output logic                      ser_valid,
  output logic                      ser_frame_end,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      idle
);

  state_t           state_q;
  state_t           state_d;
  fifo_entry_t      head;
  fifo_entry_t      wr_entry;
  logic             full;
  logic             empty;
  logic             push_c;
  logic             pop_c;
  logic             rdy_q;
  logic             last_q;
  logic [CNT_W-1:0] slot_cnt;
  logic             slot_end_c;

  assign in_ready   = rdy_q && !full;
  assign push_c     = in_valid && in_ready;
  assign wr_entry   = '{last: in_last, data: in_data};
  assign idle       = empty && (state_q == IDLE);
  assign slot_end_c = (slot_cnt == CNT_W'(SLOT_LEN - 1));

  word_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .wdata (wr_entry),
    .pop   (pop_c),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state; the pop is taken on the edge that enters LOAD so the head
  // lands in parallel_out during the sl cycle.
  always_comb begin
    state_d = state_q;
    pop_c   = 1'b0;
    case (state_q)
      IDLE:    if (!empty) state_d = LOAD;
      LOAD:    state_d = SHIFT;
      SHIFT:   if (slot_end_c) state_d = empty ? IDLE : LOAD;
      default: state_d = IDLE;
    endcase
    if (state_d == LOAD) pop_c = 1'b1;
  end

  // Output registers and the one-cycle qualifier delay line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q         <= 1'b0;
      sl            <= 1'b0;
      parallel_out  <= '0;
      last_q        <= 1'b0;
      slot_cnt      <= '0;
      ser_valid     <= 1'b0;
      ser_frame_end <= 1'b0;
    end else begin
      rdy_q         <= 1'b1;
      sl            <= pop_c;
      ser_valid     <= (state_q != IDLE);
      ser_frame_end <= (state_q == SHIFT) && slot_end_c && last_q;
      if (pop_c) begin
        parallel_out <= head.data;
        last_q       <= head.last;
        slot_cnt     <= '0;
      end else if (state_d == SHIFT) begin
        slot_cnt     <= slot_cnt + CNT_W'(1);
      end
    end
  end

endmodule
